// File: rtl/priority_encoder_reg_if.sv
// Request/grant bundle for priority_encoder_reg: request vector in, registered grant out.
// Handshake: a grant is presented while out_valid=1, holds steady until out_ready=1, and is consumed on that edge.
interface priority_encoder_reg_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_code;
  logic [N-1:0] out_onehot;
  logic         any_req;
  logic [W-1:0] dbg_ptr;

  modport master (
    input  req, out_ready,
    output out_valid, out_code, out_onehot, any_req, dbg_ptr
  );

  modport slave (
    output req, out_ready,
    input  out_valid, out_code, out_onehot, any_req, dbg_ptr
  );
endinterface

// File: rtl/priority_encoder_reg.sv
// Registered priority encoder with valid/ready output: fixed priority (RR=0, highest index wins)
// or round-robin (RR=1, descending search from a pointer that moves past each consumed grant).
module priority_encoder_reg #(
  parameter int N  = 8,
  parameter int RR = 0
) (
  input logic                  clk,
  input logic                  rst,
  priority_encoder_reg_if.master bus
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [N-1:0] ONE  = N'(1);

  logic         valid_q;
  logic [W-1:0] code_q;
  logic [N-1:0] onehot_q;
  logic         any_q;
  logic [W-1:0] ptr_q;

  logic         hs;
  logic         slot_free;
  logic [W-1:0] next_ptr;
  logic [W-1:0] start;
  logic         win_found;
  logic [W-1:0] win_code;
  int           idx;

  assign hs        = valid_q && bus.out_ready;
  assign slot_free = !valid_q || bus.out_ready;
  assign next_ptr  = (code_q == '0) ? LAST : code_q - 1'b1;

  // On a handshake the replacement grant must already see the advanced pointer,
  // otherwise the just-consumed requester would win a second time back-to-back.
  always_comb begin
    start     = LAST;
    win_found = 1'b0;
    win_code  = '0;
    idx       = 0;
    if (RR != 0) start = hs ? next_ptr : ptr_q;
    for (int k = 0; k < N; k++) begin
      idx = int'(start) - k;
      if (idx < 0) idx = idx + N;
      if (!win_found && bus.req[W'(idx)]) begin
        win_found = 1'b1;
        win_code  = W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      code_q   <= '0;
      onehot_q <= '0;
      any_q    <= 1'b0;
      ptr_q    <= LAST;
    end else begin
      any_q <= |bus.req;
      if (slot_free) begin
        valid_q  <= win_found;
        code_q   <= win_found ? win_code : '0;
        onehot_q <= win_found ? (ONE << win_code) : '0;
      end
      if (RR != 0 && hs) ptr_q <= next_ptr;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_code   = code_q;
  assign bus.out_onehot = onehot_q;
  assign bus.any_req    = any_q;
  assign bus.dbg_ptr    = ptr_q;
endmodule
